// File: rtl/down_sample.sv
// 2x2 decimator: averages each 2x2 pixel block of a raster frame with rounding.
// Even rows store horizontal pair sums in a line buffer; odd rows complete the block.
module down_sample #(
    parameter int COL = 800,
    parameter int ROW = 600
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Clk_en,
    input  logic [7:0] Din,
    input  logic       valid,
    output logic [7:0] Dout,
    output logic       valid_out,
    output logic       frame_done
);

    localparam int CW = $clog2(COL);
    localparam int RW = (ROW > 2) ? $clog2(ROW) : 1;
    localparam int AW = CW - 1;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [7:0]    a;
    logic [8:0]    line_buf [COL/2];

    logic          accept;
    logic          col_last;
    logic          row_last;
    logic [AW-1:0] addr;
    logic [7:0]    avg;

    assign accept   = valid && Clk_en;
    assign col_last = (col == CW'(COL - 1));
    assign row_last = (row == RW'(ROW - 1));
    assign addr     = col[CW-1:1];

    // Largest block sum is 1020, so the rounded quotient always fits 8 bits.
    assign avg = 8'((10'(line_buf[addr]) + 10'(a) + 10'(Din) + 10'd2) >> 2);

    // Line buffer is never reset; every entry is rewritten on an even row first.
    always_ff @(posedge Clk) begin
        if (accept && col[0] && !row[0]) begin
            line_buf[addr] <= 9'(a) + 9'(Din);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            col        <= '0;
            row        <= '0;
            a          <= '0;
            Dout       <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else if (Clk_en) begin
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            if (valid) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                if (!col[0]) begin
                    a <= Din;
                end else if (row[0]) begin
                    Dout       <= avg;
                    valid_out  <= 1'b1;
                    frame_done <= col_last && row_last;
                end
            end
        end
    end

endmodule

// File: tb/tb_down_sample.sv
// Randomized scoreboard bench for down_sample (COL=8, ROW=4).
// Expected block averages are computed per frame from a pixel array.
`timescale 1ns/1ps
module tb_down_sample;

    localparam int COL = 8;
    localparam int ROW = 4;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Clk_en = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] Din = 8'd0;
    logic [7:0] Dout;
    logic       valid_out;
    logic       frame_done;

    down_sample #(.COL(COL), .ROW(ROW)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Clk_en(Clk_en),
        .Din(Din),
        .valid(valid),
        .Dout(Dout),
        .valid_out(valid_out),
        .frame_done(frame_done)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int fd_seen = 0;
    int fd_exp = 0;
    logic [8:0] exp_q[$];
    int px [ROW][COL];

    logic       en_e;
    logic       rst_e;
    logic [8:0] e;
    logic [9:0] prev = '0;

    // Monitor: one new output per enabled edge; frozen outputs while disabled.
    initial forever begin
        @(posedge Clk);
        en_e  = Clk_en;
        rst_e = Reset;
        #1;
        if (!rst_e && !Reset) begin
            if (!en_e) begin
                checks++;
                if ({valid_out, frame_done, Dout} !== prev) begin
                    errors++;
                    $display("FAIL hold: got %h want %h",
                             {valid_out, frame_done, Dout}, prev);
                end
            end else if (valid_out) begin
                if (frame_done) fd_seen++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: got Dout=%0d fd=%0b, none expected",
                             Dout, frame_done);
                end else begin
                    e = exp_q.pop_front();
                    if ({frame_done, Dout} !== e) begin
                        errors++;
                        $display("FAIL out: got Dout=%0d fd=%0b want Dout=%0d fd=%0b",
                                 Dout, frame_done, e[7:0], e[8]);
                    end
                end
            end else if (frame_done) begin
                checks++;
                errors++;
                $display("FAIL fd_alone: got frame_done=1 want 0");
            end
        end
        prev = {valid_out, frame_done, Dout};
    end

    task automatic cyc(input logic v, input logic en, input logic [7:0] d);
        valid  = v;
        Clk_en = en;
        Din    = d;
        @(negedge Clk);
    endtask

    task automatic send(input logic [7:0] d, input bit stall);
        if (stall) begin
            repeat ($urandom_range(0, 3)) begin
                if ($urandom_range(0, 1) == 1)
                    cyc(1'($urandom_range(0, 1)), 1'b0, 8'($urandom));
                else
                    cyc(1'b0, 1'b1, 8'($urandom));
            end
        end
        cyc(1'b1, 1'b1, d);
    endtask

    task automatic push_frame();
        int s;
        for (int r = 0; r < ROW / 2; r++) begin
            for (int c = 0; c < COL / 2; c++) begin
                s = px[2*r][2*c] + px[2*r][2*c+1]
                  + px[2*r+1][2*c] + px[2*r+1][2*c+1];
                exp_q.push_back({(r == ROW/2 - 1) && (c == COL/2 - 1),
                                 8'((s + 2) / 4)});
            end
        end
        fd_exp++;
    endtask

    task automatic run_frame(input bit stall, input int n);
        push_frame();
        for (int i = 0; i < n; i++) send(8'(px[i / COL][i % COL]), stall);
        valid = 1'b0;
    endtask

    task automatic fill_const(input int v);
        for (int r = 0; r < ROW; r++)
            for (int c = 0; c < COL; c++) px[r][c] = v;
    endtask

    task automatic fill_rand();
        for (int r = 0; r < ROW; r++)
            for (int c = 0; c < COL; c++) px[r][c] = int'($urandom_range(0, 255));
    endtask

    task automatic fill_round();
        fill_rand();
        px[0][0] = 10; px[0][1] = 20; px[1][0] = 30; px[1][1] = 41;
        px[0][2] = 1;  px[0][3] = 1;  px[1][2] = 1;  px[1][3] = 2;
    endtask

    // Drops any expectations of an aborted frame and checks the cleared outputs.
    task automatic do_reset();
        Reset = 1'b1;
        cyc(1'b0, 1'b1, 8'd0);
        cyc(1'b1, 1'b0, 8'd0);
        checks++;
        if ({valid_out, frame_done, Dout} !== 10'd0) begin
            errors++;
            $display("FAIL reset_out: got vo=%0b fd=%0b Dout=%0d want 0 0 0",
                     valid_out, frame_done, Dout);
        end
        foreach (exp_q[i]) if (exp_q[i][8]) fd_exp--;
        exp_q.delete();
        Reset = 1'b0;
        cyc(1'b0, 1'b1, 8'd0);
    endtask

    task automatic drain();
        repeat (4) cyc(1'b0, 1'b1, 8'd0);
    endtask

    int fd_before;

    initial begin
        @(negedge Clk);
        do_reset();

        fill_const(100); run_frame(1'b0, ROW * COL);
        fill_round();    run_frame(1'b0, ROW * COL);
        fill_const(255); run_frame(1'b0, ROW * COL);
        fill_const(0);   run_frame(1'b0, ROW * COL);
        fill_round();    run_frame(1'b1, ROW * COL);
        drain();

        fill_rand();     run_frame(1'b0, COL + 5);
        do_reset();
        fill_const(50);  run_frame(1'b0, ROW * COL);
        drain();

        fd_before = fd_seen;
        fill_const(100); run_frame(1'b0, ROW * COL);
        fill_const(200); run_frame(1'b0, ROW * COL);
        drain();
        checks++;
        if (fd_seen - fd_before != 2) begin
            errors++;
            $display("FAIL b2b_frame_done: got %0d want 2", fd_seen - fd_before);
        end

        for (int k = 0; k < 6; k++) begin
            fill_rand();
            run_frame(1'($urandom_range(0, 1)), ROW * COL);
        end
        drain();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_out: got %0d pending want 0", exp_q.size());
        end
        checks++;
        if (fd_seen != fd_exp) begin
            errors++;
            $display("FAIL frame_done_count: got %0d want %0d", fd_seen, fd_exp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
